// File: rtl/hazard_pkg.sv
// Shared types for the forwarding/hazard tracker: producer record and
// the "use register file" forwarding select code.
package hazard_pkg;

  // rd is stored zero-extended so one struct serves any REG_AW up to RD_W.
  localparam int RD_W   = 8;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic            v;
    logic [RD_W-1:0] rd;
    logic            rw;
    logic            ld;
  } entry_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Priority match of one source operand against all tracked producers;
// youngest matching producer wins, loads too young to forward flag a hazard.
module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int REG_AW     = 5,
  parameter int SEL_W      = 2
) (
  input  entry_t              entries [NUM_STAGES],
  input  logic [REG_AW-1:0]   rs,
  input  logic                rs_used,
  input  logic                ex_valid,
  output logic [SEL_W-1:0]    sel,
  output logic                hazard
);

  logic [NUM_STAGES-1:0] match;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
    assign match[gi] = entries[gi].v & entries[gi].rw & (rs != '0) &
                       (entries[gi].rd == RD_W'(rs)) & rs_used & ex_valid;
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!found && match[k]) begin
        found = 1'b1;
        if (entries[k].ld && (k + 1) < LOAD_STAGE) hazard = 1'b1;
        else                                       sel    = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard unit: shift register of in-flight producers,
// per-port forwarding select, stall generation and saturating stall counter.
module fwd_hazard_tracker
  import hazard_pkg::*;
#(
  parameter  int NUM_RS     = 2,
  parameter  int NUM_STAGES = 2,
  parameter  int LOAD_STAGE = 2,
  parameter  int REG_AW     = 5,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_flush,
  input  logic [NUM_RS*REG_AW-1:0]  ex_rs,
  input  logic [NUM_RS-1:0]         ex_rs_used,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_is_load,
  output logic [NUM_RS*SEL_W-1:0]   fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  entry_t                   entries_q [NUM_STAGES];
  entry_t                   entries_d [NUM_STAGES];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_RS-1:0]        hazard;
  logic [NUM_RS*SEL_W-1:0]  sel_raw;

  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_port
    fwd_port_sel #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .REG_AW     (REG_AW),
      .SEL_W      (SEL_W)
    ) u_sel (
      .entries  (entries_q),
      .rs       (ex_rs[gi*REG_AW +: REG_AW]),
      .rs_used  (ex_rs_used[gi]),
      .ex_valid (ex_valid),
      .sel      (sel_raw[gi*SEL_W +: SEL_W]),
      .hazard   (hazard[gi])
    );
  end

  // A flushed consumer never stalls; outputs are held quiet during reset.
  assign stall     = rst_n & ~ex_flush & (|hazard);
  assign fwd_sel   = rst_n ? sel_raw : '0;
  assign stall_cnt = cnt_q;

  always_comb begin
    entries_d[0].v  = ex_valid & ~stall & ~ex_flush;
    entries_d[0].rd = RD_W'(ex_rd);
    entries_d[0].rw = ex_regwrite;
    entries_d[0].ld = ex_is_load;
    for (int k = 1; k < NUM_STAGES; k++) entries_d[k] = entries_q[k-1];
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) entries_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) entries_q[k] <= entries_d[k];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Randomised + directed bench for fwd_hazard_tracker: two configurations
// (2 stages/load at 2, 3 stages/load at 3 with a narrow counter) vs a history model.
module tb_fwd_hazard_tracker;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, ex_flush, ex_regwrite, ex_is_load;
  logic [9:0]  ex_rs;
  logic [1:0]  ex_rs_used;
  logic [4:0]  ex_rd;
  logic [3:0]  a_sel, b_sel;
  logic        a_stall, b_stall;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_tracker #(.NUM_RS(2), .NUM_STAGES(2), .LOAD_STAGE(2), .REG_AW(5), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_rs(ex_rs),
    .ex_rs_used(ex_rs_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .fwd_sel(a_sel), .stall(a_stall), .stall_cnt(a_cnt));

  fwd_hazard_tracker #(.NUM_RS(2), .NUM_STAGES(3), .LOAD_STAGE(3), .REG_AW(5), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_rs(ex_rs),
    .ex_rs_used(ex_rs_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .fwd_sel(b_sel), .stall(b_stall), .stall_cnt(b_cnt));

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } rec_t;
  typedef rec_t rec_q_t[$];

  // Issue history, front = most recently issued (stage 1).
  rec_q_t hist_a, hist_b;
  int     cnt_a = 0, cnt_b = 0;
  bit     st_a = 0, st_b = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_port(input rec_q_t h, input int ls, input bit [4:0] rs,
                                   input bit used, input bit valid,
                                   output int sel, output bit hz);
    sel = 0;
    hz  = 0;
    if (!used || !valid || rs == 0) return;
    for (int k = 0; k < h.size(); k++) begin
      if (h[k].v && h[k].rw && h[k].rd == rs) begin
        if (h[k].ld && (k + 1) < ls) hz = 1;
        else                         sel = k + 1;
        return;
      end
    end
  endfunction

  task automatic eval_model(input rec_q_t h, input int ls,
                            output int s0, output int s1, output bit st);
    bit hz0, hz1;
    ref_port(h, ls, ex_rs[4:0], ex_rs_used[0], ex_valid, s0, hz0);
    ref_port(h, ls, ex_rs[9:5], ex_rs_used[1], ex_valid, s1, hz1);
    st = (hz0 || hz1) && !ex_flush;
    if (!rst_n) begin
      s0 = 0;
      s1 = 0;
      st = 0;
    end
  endtask

  function automatic rec_q_t next_hist(input rec_q_t h, input int ns, input bit st);
    rec_q_t q;
    rec_t   r;
    q = h;
    if (!rst_n) begin
      q.delete();
      return q;
    end
    r.v  = ex_valid && !st && !ex_flush;
    r.rd = ex_rd;
    r.rw = ex_regwrite;
    r.ld = ex_is_load;
    q.push_front(r);
    while (q.size() > ns) void'(q.pop_back());
    return q;
  endfunction

  task automatic check_cycle();
    int s0, s1;
    @(negedge clk);
    eval_model(hist_a, 2, s0, s1, st_a);
    check_val("a_sel0", int'(a_sel[1:0]), s0);
    check_val("a_sel1", int'(a_sel[3:2]), s1);
    check_val("a_stall", int'(a_stall), int'(st_a));
    check_val("a_cnt", int'(a_cnt), cnt_a);
    eval_model(hist_b, 3, s0, s1, st_b);
    check_val("b_sel0", int'(b_sel[1:0]), s0);
    check_val("b_sel1", int'(b_sel[3:2]), s1);
    check_val("b_stall", int'(b_stall), int'(st_b));
    check_val("b_cnt", int'(b_cnt), cnt_b);
    $display("[TB] t=%0t rst_n=%0b v=%0b fl=%0b rs=%0d/%0d used=%b rd=%0d rw=%0b ld=%0b | a sel=%0d/%0d st=%0b cnt=%0d | b sel=%0d/%0d st=%0b cnt=%0d",
             $time, rst_n, ex_valid, ex_flush, ex_rs[4:0], ex_rs[9:5], ex_rs_used, ex_rd,
             ex_regwrite, ex_is_load, a_sel[1:0], a_sel[3:2], a_stall, a_cnt,
             b_sel[1:0], b_sel[3:2], b_stall, b_cnt);
    hist_a = next_hist(hist_a, 2, st_a);
    hist_b = next_hist(hist_b, 3, st_b);
    if (!rst_n) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (st_a && cnt_a < 65535) cnt_a++;
      if (st_b && cnt_b < 7)     cnt_b++;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit fl, input bit [4:0] rs0,
                      input bit [4:0] rs1, input bit [1:0] used, input bit [4:0] rd,
                      input bit rw, input bit ld);
    @(posedge clk);
    #1;
    rst_n       = r;
    ex_valid    = v;
    ex_flush    = fl;
    ex_rs       = {rs1, rs0};
    ex_rs_used  = used;
    ex_rd       = rd;
    ex_regwrite = rw;
    ex_is_load  = ld;
    check_cycle();
  endtask

  initial begin
    int a0;
    rst_n = 0; ex_valid = 0; ex_flush = 0; ex_rs = '0; ex_rs_used = '0;
    ex_rd = '0; ex_regwrite = 0; ex_is_load = 0;

    step(0, 1, 0, 5, 5, 2'b11, 5, 1, 1);
    check_val("rst_gate_stall", int'(a_stall), 0);
    step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    check_val("rst_cnt", int'(a_cnt), 0);

    // ALU producer forwarded from stage 1, then stage 2
    step(1, 1, 0, 0, 0, 2'b00, 5, 1, 0);
    step(1, 1, 0, 5, 0, 2'b01, 9, 1, 0);
    check_val("alu_fwd1", int'(a_sel[1:0]), 1);
    check_val("alu_nostall", int'(a_stall), 0);
    step(1, 1, 0, 5, 0, 2'b01, 0, 0, 0);
    check_val("alu_fwd2", int'(a_sel[1:0]), 2);

    // Load-use: A stalls one cycle, B stalls two
    step(1, 1, 0, 0, 0, 2'b00, 6, 1, 1);
    a0 = int'(a_cnt);
    step(1, 1, 0, 0, 6, 2'b10, 0, 0, 0);
    check_val("lu_a_stall", int'(a_stall), 1);
    check_val("lu_b_stall", int'(b_stall), 1);
    check_val("lu_a_fwdrf", int'(a_sel[3:2]), 0);
    step(1, 1, 0, 0, 6, 2'b10, 0, 0, 0);
    check_val("lu_a_release", int'(a_stall), 0);
    check_val("lu_a_fwd2", int'(a_sel[3:2]), 2);
    check_val("lu_a_cnt", int'(a_cnt), a0 + 1);
    check_val("lu_b_stall2", int'(b_stall), 1);
    step(1, 1, 0, 0, 6, 2'b10, 0, 0, 0);
    check_val("lu_b_release", int'(b_stall), 0);
    check_val("lu_b_fwd3", int'(b_sel[3:2]), 3);

    // x0 never forwards
    step(1, 1, 0, 0, 0, 2'b00, 0, 1, 0);
    step(1, 1, 0, 0, 0, 2'b01, 0, 1, 0);
    check_val("x0_sel", int'(a_sel[1:0]), 0);

    // Youngest producer wins
    step(1, 1, 0, 0, 0, 2'b00, 7, 1, 0);
    step(1, 1, 0, 0, 0, 2'b00, 7, 1, 0);
    step(1, 1, 0, 7, 0, 2'b01, 0, 0, 0);
    check_val("youngest", int'(a_sel[1:0]), 1);

    // Flush suppresses the stall and inserts a bubble
    step(1, 1, 0, 0, 0, 2'b00, 8, 1, 1);
    step(1, 1, 1, 8, 0, 2'b01, 3, 1, 0);
    check_val("flush_a_stall", int'(a_stall), 0);
    check_val("flush_b_stall", int'(b_stall), 0);
    step(1, 1, 0, 3, 0, 2'b01, 0, 0, 0);
    check_val("flush_bubble", int'(a_sel[1:0]), 0);

    // Unused operand never stalls
    step(1, 1, 0, 0, 0, 2'b00, 8, 1, 1);
    step(1, 1, 0, 8, 0, 2'b00, 0, 0, 0);
    check_val("unused_stall", int'(a_stall), 0);

    // Reset asserted in the middle of a load-use stall
    step(1, 1, 0, 0, 0, 2'b00, 8, 1, 1);
    step(1, 1, 0, 8, 0, 2'b01, 0, 0, 0);
    check_val("mid_b_stall", int'(b_stall), 1);
    step(0, 1, 0, 8, 0, 2'b01, 0, 0, 0);
    check_val("mid_rst_gate", int'(b_stall), 0);
    step(1, 1, 0, 8, 0, 2'b01, 0, 0, 0);
    check_val("mid_rst_stall", int'(b_stall), 0);
    check_val("mid_rst_cnt", int'(b_cnt), 0);
    check_val("mid_rst_sel", int'(b_sel[1:0]), 0);

    // Random traffic; a stalled consumer is held as the pipeline would hold it
    for (int i = 0; i < 3000; i++) begin
      bit       r, v, fl, rw, ld;
      bit [4:0] rs0, rs1, rd;
      bit [1:0] used;
      r  = ($urandom_range(99) != 0);
      fl = ($urandom_range(9) == 0);
      if ((st_a || st_b) && rst_n) begin
        v = ex_valid; rs0 = ex_rs[4:0]; rs1 = ex_rs[9:5]; used = ex_rs_used;
        rd = ex_rd; rw = ex_regwrite; ld = ex_is_load;
      end else begin
        v    = ($urandom_range(9) != 0);
        rs0  = 5'($urandom_range(3));
        rs1  = 5'($urandom_range(3));
        used = 2'($urandom_range(3));
        rd   = 5'($urandom_range(3));
        rw   = ($urandom_range(4) != 0);
        ld   = ($urandom_range(2) == 0);
      end
      step(r, v, fl, rs0, rs1, used, rd, rw, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
